// File: rtl/luks_pkg.sv
// Shared definitions for the LUKS sensor responder: FSM encoding, frame header
// constant and frame-length helper.
package luks_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_TAIL  = 2'd2
    } luks_state_e;

    localparam logic [3:0] LUKS_HEADER = 4'b0000;

    function automatic int frame_len(input int data_w);
        return data_w + 4;
    endfunction

endpackage

// File: rtl/luks_sync.sv
// Multi-flop synchronizer for one asynchronous input, plus a one-cycle-delayed
// copy of the synchronized level so the parent can detect edges.
module luks_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic lvl_o,
    output logic prev_o
);

    logic [STAGES-1:0] sync_q;
    logic              prev_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q <= '1;
            prev_q <= 1'b1;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
            prev_q <= sync_q[STAGES-1];
        end
    end

    assign lvl_o  = sync_q[STAGES-1];
    assign prev_o = prev_q;

endmodule

// File: rtl/luks_sensor_responder.sv
// SPI mode-0 responder returning a header-prefixed sensor sample per frame.
// Optional feature: define LUKS_SENSOR_RAMP_EN to send a ramp counter when no fresh sample is held.
module luks_sensor_responder
    import luks_pkg::*;
#(
    parameter int DATA_W      = 12,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cs_n,
    input  logic              sclk,
    output logic              miso,
    output logic              miso_oe,
    input  logic [DATA_W-1:0] sample_in,
    input  logic              sample_valid,
    output logic              sample_ready,
    output logic              frame_done,
    output logic              frame_abort
);

    localparam int FRAME_W = frame_len(DATA_W);
    localparam int CNT_W   = $clog2(FRAME_W + 1);

    logic cs_lvl, cs_prev, sclk_lvl, sclk_prev;

    luks_sync #(.STAGES(SYNC_STAGES)) u_cs_sync (
        .clk    (clk),
        .rst_n  (rst_n),
        .d_i    (cs_n),
        .lvl_o  (cs_lvl),
        .prev_o (cs_prev)
    );

    luks_sync #(.STAGES(SYNC_STAGES)) u_sclk_sync (
        .clk    (clk),
        .rst_n  (rst_n),
        .d_i    (sclk),
        .lvl_o  (sclk_lvl),
        .prev_o (sclk_prev)
    );

    logic cs_fall, cs_rise, sclk_fall;
    assign cs_fall   =  cs_prev & ~cs_lvl;
    assign cs_rise   = ~cs_prev &  cs_lvl;
    assign sclk_fall =  sclk_prev & ~sclk_lvl;

    luks_state_e        state_q, state_d;
    logic [FRAME_W-1:0] shift_q, shift_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [DATA_W-1:0]  hold_q, hold_d;
    logic               full_q, full_d;
    logic               armed_q, armed_d;
    logic [SYNC_STAGES-1:0] settle_q, settle_d;
    logic               done_q, done_d;
    logic               abort_q, abort_d;
`ifdef LUKS_SENSOR_RAMP_EN
    logic [DATA_W-1:0]  ramp_q, ramp_d;
`endif

    logic              accept, frame_load;
    logic [DATA_W-1:0] send_val;

    assign accept     = sample_valid & ~full_q;
    // A frame may only start once cs_n has been seen high on genuinely sampled
    // data, so a chip select already low across reset never starts a frame.
    assign frame_load = (state_q == ST_IDLE) & cs_fall & armed_q;
`ifdef LUKS_SENSOR_RAMP_EN
    assign send_val   = full_q ? hold_q : ramp_q;
`else
    assign send_val   = hold_q;
`endif

    always_comb begin
        state_d  = state_q;
        shift_d  = shift_q;
        cnt_d    = cnt_q;
        hold_d   = hold_q;
        full_d   = full_q;
        done_d   = 1'b0;
        abort_d  = 1'b0;
        settle_d = {settle_q[SYNC_STAGES-2:0], 1'b1};
        armed_d  = armed_q | (settle_q[SYNC_STAGES-1] & cs_lvl);
`ifdef LUKS_SENSOR_RAMP_EN
        ramp_d   = ramp_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (frame_load) begin
                    shift_d = {LUKS_HEADER, send_val};
                    cnt_d   = '0;
                    full_d  = 1'b0;
                    state_d = ST_SHIFT;
`ifdef LUKS_SENSOR_RAMP_EN
                    if (!full_q) ramp_d = ramp_q + 1'b1;
`endif
                end
            end
            ST_SHIFT: begin
                if (cs_rise) begin
                    abort_d = 1'b1;
                    shift_d = '0;
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end else if (sclk_fall) begin
                    shift_d = {shift_q[FRAME_W-2:0], 1'b0};
                    cnt_d   = cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(FRAME_W - 1)) state_d = ST_TAIL;
                end
            end
            ST_TAIL: begin
                if (cs_rise) begin
                    done_d  = 1'b1;
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // Accept after the load so a same-cycle load sends the old value.
        if (accept) begin
            hold_d = sample_in;
            full_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            shift_q  <= '0;
            cnt_q    <= '0;
            hold_q   <= '0;
            full_q   <= 1'b0;
            armed_q  <= 1'b0;
            settle_q <= '0;
            done_q   <= 1'b0;
            abort_q  <= 1'b0;
`ifdef LUKS_SENSOR_RAMP_EN
            ramp_q   <= '0;
`endif
        end else begin
            state_q  <= state_d;
            shift_q  <= shift_d;
            cnt_q    <= cnt_d;
            hold_q   <= hold_d;
            full_q   <= full_d;
            armed_q  <= armed_d;
            settle_q <= settle_d;
            done_q   <= done_d;
            abort_q  <= abort_d;
`ifdef LUKS_SENSOR_RAMP_EN
            ramp_q   <= ramp_d;
`endif
        end
    end

    assign miso         = (state_q == ST_SHIFT) & shift_q[FRAME_W-1];
    assign miso_oe      = (state_q != ST_IDLE);
    assign sample_ready = ~full_q;
    assign frame_done   = done_q;
    assign frame_abort  = abort_q;

endmodule

// File: tb/tb_luks_sensor_responder.sv
// Directed and randomized checks of luks_sensor_responder against a
// transaction-level model of the holding register / ramp behaviour.
module tb_luks_sensor_responder;

    localparam int DATA_W = 12;
    localparam int SYNC   = 2;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              cs_n = 1'b1;
    logic              sclk = 1'b0;
    logic              miso, miso_oe, sample_ready, frame_done, frame_abort;
    logic [DATA_W-1:0] sample_in = '0;
    logic              sample_valid = 1'b0;

    luks_sensor_responder #(.DATA_W(DATA_W), .SYNC_STAGES(SYNC)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cs_n         (cs_n),
        .sclk         (sclk),
        .miso         (miso),
        .miso_oe      (miso_oe),
        .sample_in    (sample_in),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .frame_done   (frame_done),
        .frame_abort  (frame_abort)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int done_seen = 0;
    int abort_seen = 0;
    int last_done, last_abort;

    always @(negedge clk) begin
        if (frame_done === 1'b1) done_seen++;
        if (frame_abort === 1'b1) abort_seen++;
    end

    // Reference model: a one-entry mailbox plus (optionally) a ramp source.
    logic [DATA_W-1:0] m_hold = '0;
    bit                m_full = 1'b0;
    logic [DATA_W-1:0] m_ramp = '0;

    task automatic model_reset();
        m_hold = '0;
        m_full = 1'b0;
        m_ramp = '0;
    endtask

    task automatic model_load(output logic [15:0] f);
        if (m_full) begin
            f = {4'h0, m_hold};
            m_full = 1'b0;
        end else begin
`ifdef LUKS_SENSOR_RAMP_EN
            f = {4'h0, m_ramp};
            m_ramp = m_ramp + 1'b1;
`else
            f = {4'h0, m_hold};
`endif
        end
    endtask

    task automatic model_write(input logic [DATA_W-1:0] v);
        if (!m_full) begin
            m_hold = v;
            m_full = 1'b1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic write_sample(input logic [DATA_W-1:0] v);
        @(negedge clk);
        check("write_ready", {31'd0, sample_ready}, {31'd0, ~m_full});
        sample_in = v;
        sample_valid = 1'b1;
        @(negedge clk);
        sample_valid = 1'b0;
        model_write(v);
    endtask

    task automatic sclk_cycles(input int n, output logic [31:0] w);
        w = '0;
        for (int i = 0; i < n; i++) begin
            sclk = 1'b1;
            w = {w[30:0], miso};
            repeat (5) @(negedge clk);
            sclk = 1'b0;
            repeat (5) @(negedge clk);
        end
    endtask

    task automatic do_frame(input int n, output logic [31:0] w);
        int d0, a0;
        d0 = done_seen;
        a0 = abort_seen;
        @(negedge clk);
        cs_n = 1'b0;
        repeat (8) @(negedge clk);
        check("frame_oe", {31'd0, miso_oe}, 32'd1);
        sclk_cycles(n, w);
        cs_n = 1'b1;
        repeat (8) @(negedge clk);
        last_done = done_seen - d0;
        last_abort = abort_seen - a0;
    endtask

    logic [31:0] w, w2;
    logic [15:0] exp_f, exp_next;
    int          d0, a0;

    initial begin
        // Reset
        rst_n = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        check("rst_miso", {31'd0, miso}, 32'd0);
        check("rst_oe", {31'd0, miso_oe}, 32'd0);
        check("rst_ready", {31'd0, sample_ready}, 32'd1);
        check("rst_done", {31'd0, frame_done}, 32'd0);
        check("rst_abort", {31'd0, frame_abort}, 32'd0);
        repeat (6) @(negedge clk);

        // Single write then one full frame
        write_sample(12'hA5C);
        check("full_ready", {31'd0, sample_ready}, 32'd0);
        do_frame(16, w);
        model_load(exp_f);
        check("basic_word", w, {16'd0, exp_f});
        check("basic_const", w, 32'h0000_0A5C);
        check("basic_done", last_done, 1);
        check("basic_abort", last_abort, 0);
        check("basic_ready", {31'd0, sample_ready}, 32'd1);
        check("idle_oe", {31'd0, miso_oe}, 32'd0);
        check("idle_miso", {31'd0, miso}, 32'd0);

        // Two frames without a new write
        for (int k = 0; k < 2; k++) begin
            do_frame(16, w);
            model_load(exp_f);
            check("resend_word", w, {16'd0, exp_f});
            check("resend_done", last_done, 1);
        end

        // Abort after 7 sclk cycles
        do_frame(7, w);
        model_load(exp_f);
        check("abort_pulse", last_abort, 1);
        check("abort_nodone", last_done, 0);
        check("abort_oe", {31'd0, miso_oe}, 32'd0);
        check("abort_miso", {31'd0, miso}, 32'd0);

        // Write collides with the frame-load cycle
        d0 = done_seen;
        @(negedge clk);
        check("coll_ready0", {31'd0, sample_ready}, 32'd1);
        cs_n = 1'b0;
        repeat (SYNC) @(negedge clk);
        check("coll_pre_oe", {31'd0, miso_oe}, 32'd0);
        sample_in = 12'h123;
        sample_valid = 1'b1;
        @(negedge clk);
        sample_valid = 1'b0;
        model_load(exp_f);
        model_write(12'h123);
        check("coll_post_oe", {31'd0, miso_oe}, 32'd1);
        check("coll_ready1", {31'd0, sample_ready}, 32'd0);
        repeat (6) @(negedge clk);
        sclk_cycles(16, w);
        check("coll_ready2", {31'd0, sample_ready}, 32'd0);
        cs_n = 1'b1;
        repeat (8) @(negedge clk);
        check("coll_word", w, {16'd0, exp_f});
        check("coll_done", done_seen - d0, 1);
        check("coll_ready3", {31'd0, sample_ready}, 32'd0);
        do_frame(16, w);
        model_load(exp_next);
        check("coll_next", w, {16'd0, exp_next});
        check("coll_next_const", w, 32'h0000_0123);
        check("coll_next_ready", {31'd0, sample_ready}, 32'd1);

        // Overlong frame: trailing bits are zero, one done pulse
        write_sample(DATA_W'($urandom_range(0, 4095)));
        do_frame(20, w);
        model_load(exp_f);
        check("long_word", {16'd0, w[19:4]}, {16'd0, exp_f});
        check("long_tail", {28'd0, w[3:0]}, 32'd0);
        check("long_done", last_done, 1);

        // Reset in the middle of a frame
        write_sample(DATA_W'($urandom_range(1, 4095)));
        d0 = done_seen;
        a0 = abort_seen;
        @(negedge clk);
        cs_n = 1'b0;
        repeat (8) @(negedge clk);
        sclk_cycles(9, w);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        check("mrst_oe", {31'd0, miso_oe}, 32'd0);
        check("mrst_miso", {31'd0, miso}, 32'd0);
        check("mrst_ready", {31'd0, sample_ready}, 32'd1);
        check("mrst_done", {31'd0, frame_done}, 32'd0);
        check("mrst_abort", {31'd0, frame_abort}, 32'd0);
        repeat (6) @(negedge clk);
        sclk_cycles(4, w2);
        check("mrst_nostart", {31'd0, miso_oe}, 32'd0);
        cs_n = 1'b1;
        repeat (8) @(negedge clk);
        check("mrst_nopulse_d", done_seen - d0, 0);
        check("mrst_nopulse_a", abort_seen - a0, 0);
        do_frame(16, w);
        model_load(exp_f);
        check("mrst_frame", w, {16'd0, exp_f});
        check("mrst_frame_done", last_done, 1);

        // Randomized writes and frames
        for (int k = 0; k < 8; k++) begin
            if ($urandom_range(0, 1) == 1) write_sample(DATA_W'($urandom));
            do_frame(16, w);
            model_load(exp_f);
            check("rand_word", w, {16'd0, exp_f});
            check("rand_done", last_done, 1);
            check("rand_ready", {31'd0, sample_ready}, 32'd1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
